ws2812_frame_sequencer: RTL and testbench

Upstream feeder for the WS2812 bit serializer: holds one frame of NUM_LEDS pixels in an internal RAM, and on Start streams them one 24-bit word at a time into the serializer. Each word is brightness-scaled, reordered to GRB and bit-reversed so the serializer's LSB-first shifting emits G7 first. Handshakes on the serializer's per-pixel done level. Host logic (UART/SPI loader, pattern generator) writes pixels through a simple write port.

---
 rtl/ws2812_pkg.sv | 33 +++
 rtl/ws2812_pixel_scale.sv | 31 +++
 rtl/ws2812_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared constants for the WS2812 pixel path: word width,
//                channel lanes, sequencer state encodings, channel scaler.
//  Revision    : 1.0  initial release
// ============================================================================
package ws2812_pkg;

    localparam int PIXEL_W = 24;

    // Channel lanes inside a host pixel word {R, G, B}
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_SCALE     = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_LOW  = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;
    localparam logic [2:0] S_FRAME_END = 3'd6;

    // (c * (b + 1)) >> 8 : b = 255 is identity, b = 0 blanks the channel
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_pixel_scale.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pixel_scale
//  Description : Brightness scale, GRB reorder and bit reversal of one pixel
//                so an LSB-first serializer emits G7 first.
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812_pixel_scale
    import ws2812_pkg::*;
(
    input  logic [PIXEL_W-1:0] i_pixel,
    input  logic [7:0]         i_brightness,
    output logic [PIXEL_W-1:0] o_word
);

    logic [7:0]         w_r;
    logic [7:0]         w_g;
    logic [7:0]         w_b;
    logic [PIXEL_W-1:0] w_pre;

    assign w_r   = scale_channel(i_pixel[R_LSB +: 8], i_brightness);
    assign w_g   = scale_channel(i_pixel[G_LSB +: 8], i_brightness);
    assign w_b   = scale_channel(i_pixel[B_LSB +: 8], i_brightness);
    assign w_pre = {w_g, w_r, w_b};

    for (genvar i = 0; i < PIXEL_W; i++) begin : g_rev
        assign o_word[i] = w_pre[PIXEL_W-1-i];
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_frame_sequencer
//  Description : Frame RAM plus sequencer that feeds scaled, GRB-ordered
//                pixel words to the WS2812 serializer one at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    parameter int BITWIDTH = 24
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                WrEn,
    input  logic [ADDR_W-1:0]   WrAddr,
    input  logic [BITWIDTH-1:0] WrData,
    input  logic [7:0]          Brightness,
    input  logic                Start,
    output logic                Busy,
    output logic                FrameDone,
    output logic [BITWIDTH-1:0] PixelData,
    output logic                PixelLoad,
    input  logic                PixelDone
);

    localparam logic [ADDR_W:0]   c_num_leds = (ADDR_W+1)'(NUM_LEDS);
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_LEDS - 1);

    logic [BITWIDTH-1:0] r_ram [NUM_LEDS];
    logic [BITWIDTH-1:0] r_rd_data;
    logic [BITWIDTH-1:0] r_pixel_data;
    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_index;
    logic                r_pending;
    logic [7:0]          r_bright;
    logic                r_load;
    logic                w_wr_ok;
    logic [BITWIDTH-1:0] w_scaled;

    assign w_wr_ok = WrEn && ({1'b0, WrAddr} < c_num_leds);

    // A write landing on the address being fetched is forwarded (write-first)
    always_ff @(posedge Clk) begin
        if (w_wr_ok) begin
            r_ram[WrAddr] <= WrData;
        end
        if (r_state == S_FETCH) begin
            r_rd_data <= (w_wr_ok && (WrAddr == r_index)) ? WrData : r_ram[r_index];
        end
    end

    ws2812_pixel_scale u_scale (
        .i_pixel      (r_rd_data),
        .i_brightness (r_bright),
        .o_word       (w_scaled)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_index      <= '0;
            r_pending    <= 1'b0;
            r_bright     <= 8'd0;
            r_pixel_data <= '0;
            r_load       <= 1'b0;
        end else begin
            // Registered so the serializer reset is a clean one-cycle pulse
            r_load <= (r_state == S_ISSUE);

            if (Start && (r_state != S_IDLE) && (r_state != S_FRAME_END)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_bright <= Brightness;
                        r_index  <= '0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_SCALE;
                S_SCALE: begin
                    r_pixel_data <= w_scaled;
                    r_state      <= S_ISSUE;
                end
                S_ISSUE: r_state <= S_WAIT_LOW;
                S_WAIT_LOW: begin
                    if (!PixelDone) begin
                        r_state <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (PixelDone) begin
                        if (r_index == c_last_idx) begin
                            r_state <= S_FRAME_END;
                        end else begin
                            r_index <= r_index + ADDR_W'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FRAME_END: begin
                    // A Start arriving right now is treated as the queued frame
                    if (r_pending || Start) begin
                        r_pending <= 1'b0;
                        r_bright  <= Brightness;
                        r_index   <= '0;
                        r_state   <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy      = (r_state != S_IDLE) && (r_state != S_FRAME_END);
    assign FrameDone = (r_state == S_FRAME_END);
    assign PixelData = r_pixel_data;
    assign PixelLoad = r_load;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_frame_sequencer
//  Description : Directed self-checking bench with a behavioural serializer
//                on an 8-LED and a 5-LED instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ws2812_frame_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;

    logic        WrEn = 1'b0;
    logic [2:0]  WrAddr = '0;
    logic [23:0] WrData = '0;
    logic [7:0]  Brightness = 8'd255;
    logic        Start = 1'b0;
    logic        Busy, FrameDone, PixelLoad;
    logic [23:0] PixelData;
    logic        PixelDone = 1'b1;

    logic        WrEn5 = 1'b0;
    logic [2:0]  WrAddr5 = '0;
    logic [23:0] WrData5 = '0;
    logic        Start5 = 1'b0;
    logic        Busy5, FrameDone5, PixelLoad5;
    logic [23:0] PixelData5;
    logic        PixelDone5 = 1'b1;

    int errors = 0;
    int checks = 0;

    int          load_cnt = 0;
    int          fd_cnt = 0;
    logic [23:0] load_log [256];
    int          load5_cnt = 0;
    logic [23:0] load5_log [16];
    int          done_cnt = 0;
    int          done5_cnt = 0;

    logic [23:0] pix8 [8] = '{24'hFF0000, 24'h000100, 24'h000004, 24'h000008,
                              24'h000010, 24'h000020, 24'h000040, 24'h000080};
    logic [23:0] exp8 [8] = '{24'h00FF00, 24'h000080, 24'h200000, 24'h100000,
                              24'h080000, 24'h040000, 24'h020000, 24'h010000};
    logic [23:0] pix5 [5] = '{24'h000001, 24'h000002, 24'h000004, 24'h000008, 24'h000010};
    logic [23:0] exp5 [5] = '{24'h800000, 24'h400000, 24'h200000, 24'h100000, 24'h080000};

    always #5 Clk = ~Clk;

    ws2812_frame_sequencer #(.NUM_LEDS(8)) u_dut (
        .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Brightness(Brightness), .Start(Start), .Busy(Busy), .FrameDone(FrameDone),
        .PixelData(PixelData), .PixelLoad(PixelLoad), .PixelDone(PixelDone)
    );

    ws2812_frame_sequencer #(.NUM_LEDS(5)) u_dut5 (
        .Clk(Clk), .Reset(Reset), .WrEn(WrEn5), .WrAddr(WrAddr5), .WrData(WrData5),
        .Brightness(Brightness), .Start(Start5), .Busy(Busy5), .FrameDone(FrameDone5),
        .PixelData(PixelData5), .PixelLoad(PixelLoad5), .PixelDone(PixelDone5)
    );

    // Serializer models: done drops after PixelLoad, returns 30 cycles later
    always @(posedge Clk) begin
        if (PixelLoad) begin
            PixelDone <= 1'b0;
            done_cnt  <= 30;
        end else if (done_cnt != 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) PixelDone <= 1'b1;
        end
        if (PixelLoad5) begin
            PixelDone5 <= 1'b0;
            done5_cnt  <= 30;
        end else if (done5_cnt != 0) begin
            done5_cnt <= done5_cnt - 1;
            if (done5_cnt == 1) PixelDone5 <= 1'b1;
        end
    end

    always @(negedge Clk) begin
        if (PixelLoad) begin
            if (load_cnt < 256) load_log[load_cnt] = PixelData;
            load_cnt++;
        end
        if (FrameDone) fd_cnt++;
        if (PixelLoad5) begin
            if (load5_cnt < 16) load5_log[load5_cnt] = PixelData5;
            load5_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_pix(input logic [2:0] a, input logic [23:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        tick();
        WrEn = 1'b0;
    endtask

    task automatic write_pix5(input logic [2:0] a, input logic [23:0] d);
        WrEn5 = 1'b1; WrAddr5 = a; WrData5 = d;
        tick();
        WrEn5 = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] b);
        Brightness = b; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int budget);
        int n = 0;
        while (!FrameDone && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, FrameDone}, 32'd1);
    endtask

    initial begin
        int base;
        int base2;
        int fdb;
        int n;

        tick(3);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_framedone", {31'd0, FrameDone}, 32'd0);
        check("reset_pixelload", {31'd0, PixelLoad}, 32'd0);
        check("reset_pixeldata", {8'd0, PixelData}, 32'd0);
        Reset = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) write_pix(3'(k), pix8[k]);

        // First frame: latency, hold, order, FrameDone/Busy alignment
        base = load_cnt;
        fdb  = fd_cnt;
        start_frame(8'd255);
        check("busy_after_start", {31'd0, Busy}, 32'd1);
        check("no_load_t1", {31'd0, PixelLoad}, 32'd0);
        tick(2);
        check("no_load_t2", {31'd0, PixelLoad}, 32'd0);
        tick();
        check("load_t3", {31'd0, PixelLoad}, 32'd1);
        check("pix0_red", {8'd0, PixelData}, 32'h00FF00);
        tick(10);
        check("pix0_hold", {8'd0, PixelData}, 32'h00FF00);
        wait_fd("frame1_done", 1000);
        check("busy_low_at_fd", {31'd0, Busy}, 32'd0);
        tick();
        check("fd_one_cycle", {31'd0, FrameDone}, 32'd0);
        check("frame1_loads", load_cnt - base, 32'd8);
        check("frame1_fd_count", fd_cnt - fdb, 32'd1);
        for (int k = 0; k < 8; k++)
            check($sformatf("frame1_px%0d", k), {8'd0, load_log[base+k]}, {8'd0, exp8[k]});

        write_pix(3'd0, 24'h800000);
        base = load_cnt;
        start_frame(8'd255);
        wait_fd("bitorder_done", 1000);
        check("bitorder_r7", {8'd0, load_log[base]}, 32'h000100);

        // Brightness must be latched at Start, not tracked afterwards
        write_pix(3'd0, 24'hC86400);
        base = load_cnt;
        start_frame(8'd127);
        Brightness = 8'd255;
        wait_fd("b127_done", 1000);
        check("b127_pix0", {8'd0, load_log[base]}, 32'h00264C);

        write_pix(3'd0, 24'hFFFFFF);
        base = load_cnt;
        start_frame(8'd0);
        wait_fd("b0_done", 1000);
        check("b0_pix0", {8'd0, load_log[base]}, 32'd0);
        check("b0_pix7", {8'd0, load_log[base+7]}, 32'd0);

        // Two Starts mid-frame queue exactly one extra frame
        write_pix(3'd0, pix8[0]);
        base = load_cnt;
        fdb  = fd_cnt;
        start_frame(8'd255);
        tick(50);
        Start = 1'b1; tick(); Start = 1'b0;
        tick(20);
        Start = 1'b1; tick(); Start = 1'b0;
        wait_fd("pend_fd1", 1000);
        tick();
        check("pend_no_gap", {31'd0, Busy}, 32'd1);
        wait_fd("pend_fd2", 1000);
        tick(150);
        check("pend_loads", load_cnt - base, 32'd16);
        check("pend_fd_count", fd_cnt - fdb, 32'd2);
        check("pend_idle", {31'd0, Busy}, 32'd0);
        check("pend_px8", {8'd0, load_log[base+8]}, {8'd0, exp8[0]});
        check("pend_px15", {8'd0, load_log[base+15]}, {8'd0, exp8[7]});

        // Reset during WAIT_HIGH of pixel 3
        base = load_cnt;
        start_frame(8'd255);
        n = 0;
        while ((load_cnt - base) < 4 && n < 1000) begin
            tick();
            n++;
        end
        check("rst_reach_px3", {31'd0, (load_cnt - base) >= 4}, 32'd1);
        tick(5);
        Reset = 1'b1;
        tick();
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_framedone", {31'd0, FrameDone}, 32'd0);
        check("rst_pixelload", {31'd0, PixelLoad}, 32'd0);
        check("rst_pixeldata", {8'd0, PixelData}, 32'd0);
        Reset = 1'b0;
        tick(100);
        check("rst_no_more_loads", load_cnt - base, 32'd4);
        base2 = load_cnt;
        start_frame(8'd255);
        wait_fd("rst_resend_done", 1000);
        check("rst_resend_loads", load_cnt - base2, 32'd8);
        check("rst_resend_px0", {8'd0, load_log[base2]}, {8'd0, exp8[0]});
        check("rst_resend_px3", {8'd0, load_log[base2+3]}, {8'd0, exp8[3]});

        // Out-of-range write on the 5-LED instance is ignored
        for (int k = 0; k < 5; k++) write_pix5(3'(k), pix5[k]);
        write_pix5(3'd5, 24'hFFFFFF);
        Brightness = 8'd255;
        Start5 = 1'b1; tick(); Start5 = 1'b0;
        n = 0;
        while (!FrameDone5 && n < 1000) begin
            tick();
            n++;
        end
        check("n5_done", {31'd0, FrameDone5}, 32'd1);
        check("n5_loads", load5_cnt, 32'd5);
        for (int k = 0; k < 5; k++)
            check($sformatf("n5_px%0d", k), {8'd0, load5_log[k]}, {8'd0, exp5[k]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
